// File: rtl/gshare_branch_predictor_pkg.sv
// Shared pipeline types for the gshare direction predictor and the pipe
// registers that carry its PHT index to the resolving stage.
package gshare_branch_predictor_pkg;

  localparam int DEFAULT_PHT_INDEX_WIDTH = 8;
  localparam int DEFAULT_HISTORY_LEN     = 8;

  typedef logic [DEFAULT_PHT_INDEX_WIDTH-1:0] PhtIndex;
  typedef logic [1:0]                         BranchCounter;

  localparam BranchCounter STRONG_NT = 2'b00;
  localparam BranchCounter WEAK_NT   = 2'b01;
  localparam BranchCounter WEAK_T    = 2'b10;
  localparam BranchCounter STRONG_T  = 2'b11;

  typedef struct packed {
    logic [31:0] pc;
    logic        isBranch;
    logic        predTaken;
    PhtIndex     predictIndex;
  } DecodeStagePipeReg;

  typedef struct packed {
    logic [31:0] pc;
    logic        isBranch;
    logic        predTaken;
    PhtIndex     predictIndex;
  } ExecuteStagePipeReg;

endpackage

// File: rtl/gshare_branch_predictor_sat_counter2.sv
// Next-state of a 2-bit saturating direction counter; pure combinational,
// holds at STRONG_NT / STRONG_T instead of wrapping.
module gshare_branch_predictor_sat_counter2
  import gshare_branch_predictor_pkg::*;
(
  input  logic [1:0] cur_i,
  input  logic       taken_i,
  output logic [1:0] next_o
);

  always_comb begin
    next_o = cur_i;
    case (cur_i)
      STRONG_NT: next_o = taken_i ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   next_o = taken_i ? WEAK_T   : STRONG_NT;
      WEAK_T:    next_o = taken_i ? STRONG_T : WEAK_NT;
      default:   next_o = taken_i ? STRONG_T : WEAK_T;
    endcase
  end

endmodule

// File: rtl/gshare_branch_predictor.sv
// Gshare direction predictor: combinational PHT read at fetch, one counter
// write per cycle at resolve, speculative history repaired on mispredict.
module gshare_branch_predictor
  import gshare_branch_predictor_pkg::*;
#(
  parameter int         PHT_INDEX_WIDTH = DEFAULT_PHT_INDEX_WIDTH,
  parameter int         HISTORY_LEN     = DEFAULT_HISTORY_LEN,
  parameter logic [1:0] CNT_RESET       = WEAK_NT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                fetchPc,
  input  logic                       fetchIsBranch,
  output logic                       isBranchTakenPredicted,
  output logic [PHT_INDEX_WIDTH-1:0] predictIndex,
  input  logic                       updateValid,
  input  logic [PHT_INDEX_WIDTH-1:0] updateIndex,
  input  logic                       updateTaken,
  input  logic                       updateMispredict,
  output logic [31:0]                perfPredictions,
  output logic [31:0]                perfMispredicts
);

  localparam int PHT_ENTRIES = 1 << PHT_INDEX_WIDTH;

  logic [1:0]                 pht_q [PHT_ENTRIES];
  logic [HISTORY_LEN-1:0]     spec_ghr_q,   spec_ghr_d;
  logic [HISTORY_LEN-1:0]     commit_ghr_q, commit_ghr_d;
  logic [31:0]                perf_pred_q,  perf_pred_d;
  logic [31:0]                perf_mis_q,   perf_mis_d;

  logic [PHT_INDEX_WIDTH-1:0] ghr_ext;
  logic [HISTORY_LEN-1:0]     commit_shift;
  logic [HISTORY_LEN-1:0]     spec_shift;
  logic [1:0]                 upd_cur;
  logic [1:0]                 upd_next;
  logic                       unused_pc_bits;

  // Word-aligned PC: the two low bits never carry index information.
  assign unused_pc_bits = ^{fetchPc[31:PHT_INDEX_WIDTH+2], fetchPc[1:0]};

  always_comb begin
    ghr_ext                  = '0;
    ghr_ext[HISTORY_LEN-1:0] = spec_ghr_q;
  end

  assign predictIndex           = fetchPc[PHT_INDEX_WIDTH+1:2] ^ ghr_ext;
  assign isBranchTakenPredicted = pht_q[predictIndex][1];

  generate
    if (HISTORY_LEN == 1) begin : g_hist1
      assign commit_shift = updateTaken;
      assign spec_shift   = isBranchTakenPredicted;
    end else begin : g_histn
      assign commit_shift = {commit_ghr_q[HISTORY_LEN-2:0], updateTaken};
      assign spec_shift   = {spec_ghr_q[HISTORY_LEN-2:0], isBranchTakenPredicted};
    end
  endgenerate

  assign upd_cur = pht_q[updateIndex];

  gshare_branch_predictor_sat_counter2 u_sat_counter2 (
    .cur_i   (upd_cur),
    .taken_i (updateTaken),
    .next_o  (upd_next)
  );

  always_comb begin
    commit_ghr_d = commit_ghr_q;
    spec_ghr_d   = spec_ghr_q;
    perf_pred_d  = perf_pred_q;
    perf_mis_d   = perf_mis_q;

    if (updateValid) begin
      commit_ghr_d = commit_shift;
    end

    // A redirect wins over a same-cycle fetch shift: that fetch is squashed.
    if (updateValid && updateMispredict) begin
      spec_ghr_d = commit_shift;
    end else if (fetchIsBranch) begin
      spec_ghr_d = spec_shift;
    end

    if (fetchIsBranch) begin
      perf_pred_d = perf_pred_q + 32'd1;
    end
    if (updateValid && updateMispredict) begin
      perf_mis_d = perf_mis_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PHT_ENTRIES; i++) begin
        pht_q[i] <= CNT_RESET;
      end
      spec_ghr_q   <= '0;
      commit_ghr_q <= '0;
      perf_pred_q  <= '0;
      perf_mis_q   <= '0;
    end else begin
      if (updateValid) begin
        pht_q[updateIndex] <= upd_next;
      end
      spec_ghr_q   <= spec_ghr_d;
      commit_ghr_q <= commit_ghr_d;
      perf_pred_q  <= perf_pred_d;
      perf_mis_q   <= perf_mis_d;
    end
  end

  assign perfPredictions = perf_pred_q;
  assign perfMispredicts = perf_mis_q;

endmodule

// File: doc/gshare_branch_predictor.md
Name: gshare_branch_predictor

Overview:
- Direction predictor directly upstream of the fetch stage.
- Fetch presents its current PC each cycle; the block returns a combinational taken/not-taken prediction and the PHT index used, which travel down the pipe with the instruction.
- Uses a gshare scheme: a PHT of 2-bit saturating counters indexed by PC XOR global history.
- The resolving stage returns branch outcomes to train the PHT and to repair speculative history on mispredict.

Parameters:
- PHT_INDEX_WIDTH, 8: log2 of PHT entry count (256 entries).
- HISTORY_LEN, 8: global history bits. Legal range 1..PHT_INDEX_WIDTH.
- CNT_RESET, 2'b01: counter reset value (weakly not-taken).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- fetchPc  in  32  PC currently held by fetch
- fetchIsBranch  in  1  fetch is advancing a branch/jump this cycle (not stalled, not squashed)
- isBranchTakenPredicted  out  1  combinational prediction for fetchPc
- predictIndex  out  PHT_INDEX_WIDTH  PHT index used for fetchPc; carried down the pipe
- updateValid  in  1  one branch/jump resolved this cycle, in program order
- updateIndex  in  PHT_INDEX_WIDTH  predictIndex that travelled with the resolved branch
- updateTaken  in  1  actual outcome (jumps report 1)
- updateMispredict  in  1  direction prediction was wrong; qualified by updateValid
- perfPredictions  out  32  count of fetchIsBranch cycles
- perfMispredicts  out  32  count of updateValid && updateMispredict cycles

Behaviour:
- State:
  - pht[2^PHT_INDEX_WIDTH] of 2-bit counters.
  - specGhr[HISTORY_LEN]: speculative history, updated at fetch.
  - commitGhr[HISTORY_LEN]: resolved history, updated at resolve.
  - The two performance counters.
- Reset (rst low, async): every pht entry = CNT_RESET; specGhr = 0; commitGhr = 0; perf counters = 0. Outputs follow combinationally from reset state, so isBranchTakenPredicted = 0.
- Index: predictIndex = fetchPc[PHT_INDEX_WIDTH+1:2] XOR zero-extended specGhr. PC bits [1:0] are ignored.
- Prediction: isBranchTakenPredicted = pht[predictIndex][1]. Zero latency, pure combinational read. Valid regardless of fetchIsBranch.
- Counter update (rising edge, updateValid=1):
  - pht[updateIndex] increments if updateTaken, else decrements.
  - Saturates at 2'b11 and 2'b00; no wrap.
  - At most one PHT write per cycle.
- commitGhr on updateValid: commitGhr <= {commitGhr[HISTORY_LEN-2:0], updateTaken}. For HISTORY_LEN=1 it is just updateTaken.
- specGhr priority, per edge:
  1. updateValid && updateMispredict: specGhr <= {commitGhr[HISTORY_LEN-2:0], updateTaken}, i.e. the new commitGhr value. A same-cycle fetchIsBranch shift is discarded because fetch is being redirected.
  2. Else if fetchIsBranch: specGhr <= {specGhr[HISTORY_LEN-2:0], isBranchTakenPredicted}.
  3. Else hold.
- Read/write collision: if updateIndex == predictIndex in the same cycle, the prediction uses the pre-update counter value (old value). There is no bypass.
- Perf counters:
  - Increment by 1 on their events and wrap modulo 2^32.
  - perfPredictions increments even in a mispredict cycle.
- updateMispredict without updateValid is ignored.
- Reset asserted mid-operation clears all state immediately, regardless of clock.

Decomposition:
- Shared package (PipelineTypes):
  - typedef PhtIndex (logic [PHT_INDEX_WIDTH-1:0]).
  - typedef BranchCounter (logic [1:0]).
  - Counter constants: STRONG_NT=2'b00, WEAK_NT=2'b01, WEAK_T=2'b10, STRONG_T=2'b11.
  - Add a PhtIndex predictIndex field to DecodeStagePipeReg and downstream pipe regs.
- One natural sub-module: sat_counter2, a pure function/module giving the next value of a 2-bit saturating counter from (current, taken). It is used by the PHT write path and unit-tested separately.

Test Plan:
1. Reset release, fetchPc=0x100 -> predictIndex=0x40, isBranchTakenPredicted=0, perf counters 0.
2. Four updateValid with updateIndex=0x40, updateTaken=1, no mispredict -> after 1st update prediction at 0x100 (GHR 0) becomes 1; counter ends at 2'b11; a 5th taken update keeps it 2'b11.
3. fetchIsBranch three cycles at fetchPc=0x100 with pht[0x40..]=WEAK_NT -> specGhr=0b000 each shift (predicted 0). Force pht entry to predict 1 -> specGhr shifts in 1 and predictIndex for 0x100 changes to 0x41.
4. specGhr=0x5A, commitGhr=0x03, updateValid+updateMispredict+updateTaken=1 with fetchIsBranch=1 in the same cycle -> next specGhr=commitGhr=0x07; perfMispredicts +1; perfPredictions +1.
5. Same-cycle updateIndex==predictIndex=0x40 from WEAK_NT with taken -> that cycle's prediction is 0; the next cycle's is 1.
6. Assert rst low asynchronously between edges after training -> all outputs and state return to reset values before the next clock edge.
